// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default widths for the fetch sequencer and its counter.
package fetch_sequencer_pkg;

  localparam int DEF_MSB      = 11;
  localparam int DEF_OPCODE_W = 5;
  localparam int DEF_CNT_W    = 16;
  localparam logic [4:0] DEF_HALT_OPCODE = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch flow control (idle/run/step/pause/halt) driving program_counter.
// Optional breakpoint support is enabled by defining FETCH_SEQ_BREAKPOINT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int MSB      = DEF_MSB,
  parameter int OPCODE_W = DEF_OPCODE_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = OPCODE_W'(DEF_HALT_OPCODE)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_step,
  input  logic [MSB-1:0]      i_pc,
  input  logic [OPCODE_W-1:0] i_opcode,
`ifdef FETCH_SEQ_BREAKPOINT_EN
  input  logic [MSB-1:0]      i_bp_addr,
  input  logic                i_bp_valid,
  output logic                o_bp_hit,
`endif
  output logic [MSB-1:0]      o_inc,
  output logic                o_pc_en,
  output logic                o_busy,
  output logic                o_halted,
  output logic [CNT_W-1:0]    o_icount
);

  state_t state_reg, state_next;
  logic   cnt_clr, cnt_inc;
  logic   is_halt, bp_stop;
  logic [MSB-1:0] pc_plus;

  assign is_halt = (i_opcode == HALT_OPCODE);
  assign pc_plus = i_pc + 1'b1;

`ifdef FETCH_SEQ_BREAKPOINT_EN
  // Breakpoints only fire when the previous cycle was also RUN, so a resume
  // from PAUSE executes the instruction sitting at the breakpoint address.
  logic prev_run_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) prev_run_reg <= 1'b0;
    else       prev_run_reg <= (state_reg == ST_RUN);
  end

  assign bp_stop = i_bp_valid && (i_pc == i_bp_addr) && prev_run_reg;
`else
  assign bp_stop = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    o_inc      = i_pc;
    o_pc_en    = 1'b1;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
`ifdef FETCH_SEQ_BREAKPOINT_EN
    o_bp_hit   = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        o_pc_en = 1'b0;
        o_inc   = '0;
        if (i_start) begin
          state_next = ST_RUN;
          cnt_clr    = 1'b1;
        end else if (i_step) begin
          state_next = ST_STEP;
          cnt_clr    = 1'b1;
        end
      end
      ST_RUN: begin
        if (is_halt) begin
          state_next = ST_HALTED;
        end else if (bp_stop) begin
          state_next = ST_PAUSE;
`ifdef FETCH_SEQ_BREAKPOINT_EN
          o_bp_hit   = 1'b1;
`endif
        end else begin
          o_inc   = pc_plus;
          cnt_inc = 1'b1;
        end
      end
      ST_STEP: begin
        state_next = is_halt ? ST_HALTED : ST_PAUSE;
        if (!is_halt) begin
          o_inc   = pc_plus;
          cnt_inc = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (i_start)     state_next = ST_RUN;
        else if (i_step) state_next = ST_STEP;
      end
      ST_HALTED: begin
        // Restart drops the enable right away so the PC is already 0 in IDLE.
        if (i_start) begin
          state_next = ST_IDLE;
          o_pc_en    = 1'b0;
          o_inc      = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        o_pc_en    = 1'b0;
        o_inc      = '0;
      end
    endcase
  end

  assign o_busy   = (state_reg == ST_RUN) || (state_reg == ST_STEP);
  assign o_halted = (state_reg == ST_HALTED);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_icount (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (o_icount)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: fetch_sequencer driving a behavioural program_counter and program ROM.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        step;
  logic [10:0] pc = '0;
  logic [4:0]  opcode;
  logic [10:0] inc;
  logic        pc_en;
  logic        busy;
  logic        halted;
  logic [15:0] icount;
  logic [4:0]  prog [0:2047];
`ifdef FETCH_SEQ_BREAKPOINT_EN
  logic [10:0] bp_addr;
  logic        bp_valid;
  logic        bp_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // program_counter: loads i_inc when enabled, otherwise 0
  always @(posedge clk) pc <= pc_en ? inc : 11'd0;
  assign opcode = prog[pc];

  fetch_sequencer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_step     (step),
    .i_pc       (pc),
    .i_opcode   (opcode),
`ifdef FETCH_SEQ_BREAKPOINT_EN
    .i_bp_addr  (bp_addr),
    .i_bp_valid (bp_valid),
    .o_bp_hit   (bp_hit),
`endif
    .o_inc      (inc),
    .o_pc_en    (pc_en),
    .o_busy     (busy),
    .o_halted   (halted),
    .o_icount   (icount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) prog[i] = 5'h01;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_pc(input string tag, input logic [10:0] target, input int limit);
    for (int i = 0; i < limit && pc != target; i++) cyc();
    check(tag, 32'(pc), 32'(target));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0;
`ifdef FETCH_SEQ_BREAKPOINT_EN
    bp_addr = '0; bp_valid = 1'b0;
`endif
    fill_nop();

    // reset release, idle
    do_reset();
    check("rst_pc_en",  32'(pc_en),  32'd0);
    check("rst_inc",    32'(inc),    32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_icount", 32'(icount), 32'd0);
    cyc(); cyc();
    check("idle_pc", 32'(pc), 32'd0);

    // continuous run to HALT at address 5
    prog[5] = 5'h00;
    pulse_start();
    check("run_busy", 32'(busy), 32'd1);
    check("run_pc0",  32'(pc),   32'd0);
    check("run_inc0", 32'(inc),  32'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("run_pc%0d", k), 32'(pc), 32'(k));
    end
    check("halt_inc_hold", 32'(inc),    32'd5);
    check("halt_icount",   32'(icount), 32'd5);
    cyc();
    check("halted",      32'(halted), 32'd1);
    check("halted_busy", 32'(busy),   32'd0);
    check("halted_pc",   32'(pc),     32'd5);
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    check("halted_step_ign", 32'(halted), 32'd1);
    check("halted_step_pc",  32'(pc),     32'd5);
    check("halted_icount",   32'(icount), 32'd5);
    pulse_start();
    check("restart_halted", 32'(halted), 32'd0);
    check("restart_icount", 32'(icount), 32'd5);
    cyc();
    check("restart_pc", 32'(pc), 32'd0);

    // single step three times
    prog[5] = 5'h01;
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      check($sformatf("step%0d_busy", k), 32'(busy), 32'd1);
      cyc();
      check($sformatf("step%0d_pc", k),     32'(pc),     32'(k));
      check($sformatf("step%0d_icount", k), 32'(icount), 32'(k));
      cyc(); cyc();
      check($sformatf("step%0d_hold", k), 32'(pc),   32'(k));
      check($sformatf("step%0d_idle", k), 32'(busy), 32'd0);
    end
    pulse_start();
    cyc(); cyc();
    check("resume_pc",     32'(pc),     32'd5);
    check("resume_icount", 32'(icount), 32'd5);

    // wrap at 0x7FF
    wait_pc("reach_7ff", 11'h7FF, 3000);
    check("wrap_inc",   32'(inc),   32'd0);
    check("wrap_pc_en", 32'(pc_en), 32'd1);
    cyc();
    check("wrap_pc",     32'(pc),     32'd0);
    check("wrap_icount", 32'(icount), 32'd2048);

    // reset mid-run at PC 9
    wait_pc("reach_9", 11'd9, 50);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_busy",   32'(busy),   32'd0);
    check("midrst_icount", 32'(icount), 32'd0);
    check("midrst_pc_en",  32'(pc_en),  32'd0);
    cyc();
    check("midrst_pc", 32'(pc), 32'd0);
    start = 1'b1; step = 1'b1;
    cyc();
    start = 1'b0; step = 1'b0;
    cyc(); cyc();
    check("both_run_pc",   32'(pc),   32'd2);
    check("both_run_busy", 32'(busy), 32'd1);

`ifdef FETCH_SEQ_BREAKPOINT_EN
    // breakpoint at 3, resume past it
    do_reset();
    bp_addr = 11'd3; bp_valid = 1'b1;
    pulse_start();
    check("bp_miss0", 32'(bp_hit), 32'd0);
    cyc(); cyc(); cyc();
    check("bp_pc",  32'(pc),     32'd3);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_inc", 32'(inc),    32'd3);
    cyc();
    check("bp_pause_pc",  32'(pc),     32'd3);
    check("bp_pause_hit", 32'(bp_hit), 32'd0);
    check("bp_pause_bsy", 32'(busy),   32'd0);
    pulse_start();
    check("bp_resume_hit", 32'(bp_hit), 32'd0);
    cyc();
    check("bp_resume_pc", 32'(pc), 32'd4);

    // HALT sitting on the breakpoint address
    do_reset();
    prog[3] = 5'h00;
    pulse_start();
    cyc(); cyc(); cyc();
    check("bphalt_pc",  32'(pc),     32'd3);
    check("bphalt_hit", 32'(bp_hit), 32'd0);
    cyc();
    check("bphalt_halted", 32'(halted), 32'd1);
    prog[3] = 5'h01;
    bp_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
